sram_1rw1r_param: RTL and testbench
===================================

SRAM_1RW1R_PARAM -- requirements
Module: sram_1rw1r_param

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 8, address width; depth = 2^ADDR_WIDTH words.
REQ-003 SHALL provide parameter WMASK_WIDTH, default 8, bits covered by one write-mask bit; NUM_WMASKS = DATA_WIDTH/WMASK_WIDTH.
REQ-004 SHALL provide parameter READ_LATENCY, default 1, legal values 1 or 2 cycles.
REQ-005 SHALL have one clock and a synchronous, active-low reset.
REQ-006 SHALL provide the following ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- csb0  in  1  port 0 active-low chip select.
- web0  in  1  port 0 active-low write enable.
- wmask0  in  NUM_WMASKS  port 0 byte/lane write mask.
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  port 0 write data.
- dout0  out  DATA_WIDTH  port 0 read data.
- dvalid0  out  1  dout0 carries newly read data this cycle.
- csb1  in  1  port 1 (read-only) active-low chip select.
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  DATA_WIDTH  port 1 read data.
- dvalid1  out  1  dout1 carries newly read data this cycle.
- collision  out  1  port 1 read coincided with a port 0 write to the same address.

Function
REQ-007 SHALL sample all port inputs on the rising clk edge; no negedge or delay-based behaviour.
REQ-008 Port 0 write (csb0=0, web0=0) SHALL update only the lanes whose wmask0 bit is 1, at the sampling edge; the new data SHALL be readable from the next edge onward.
REQ-009 Port 0 read (csb0=0, web0=1) SHALL present mem[addr0] on dout0 with dvalid0=1 exactly READ_LATENCY cycles after the sampling edge.
REQ-010 Port 1 read (csb1=0) SHALL present mem[addr1] on dout1 with dvalid1=1 exactly READ_LATENCY cycles after the sampling edge.
REQ-011 dvalid0/dvalid1 SHALL be single-cycle per accepted read; back-to-back reads SHALL produce back-to-back valid data (full throughput, one read per port per cycle).
REQ-012 dout0/dout1 SHALL hold their last read value when no read completes; never drive X after reset.
REQ-013 Port 0 write SHALL never assert dvalid0.
REQ-014 Collision = csb0=0, web0=0, wmask0!=0, csb1=0, addr0==addr1 on the same edge; collision SHALL assert in the same cycle as the corresponding dvalid1, for one cycle.
REQ-015 Write with wmask0=0 SHALL leave memory unchanged and SHALL NOT raise collision.
REQ-016 Memory SHALL be RAM_DEPTH x DATA_WIDTH with no address wrap beyond the 2^ADDR_WIDTH range (full address decode).
REQ-017 Elaboration SHALL fail if DATA_WIDTH mod WMASK_WIDTH != 0 or READ_LATENCY not in {1,2}.

Reset
REQ-018 While rst_n=0 at an edge: dout0, dout1 = 0; dvalid0, dvalid1, collision = 0; all read-pipeline stages cleared.
REQ-019 Accesses sampled while rst_n=0 SHALL be ignored (no write, no read issued).
REQ-020 Reads in flight when reset asserts SHALL be dropped; no dvalid for them after reset release.
REQ-021 Memory contents SHALL NOT be reset.

Configuration
REQ-022 Macro SRAM_BYPASS_EN: when defined, a collision read SHALL return merged data (masked lanes from din0, other lanes old contents); when undefined, it SHALL return the pre-write contents. collision SHALL assert in both builds.

Verification
REQ-023 Write addr0=0x10, din0=0xA5A5_A5A5, wmask0=0xF; next cycle read port 0 addr 0x10 -> dout0=0xA5A5_A5A5, dvalid0=1 after READ_LATENCY.
REQ-024 mem[0x20]=0x1122_3344; write din0=0xFFFF_FFFF wmask0=0x5; read port 1 -> dout1=0x11FF_33FF.
REQ-025 mem[0x30]=0; same-edge write 0xDEAD_BEEF mask 0xF and port 1 read 0x30 -> collision=1 with dvalid1; dout1=0xDEAD_BEEF with SRAM_BYPASS_EN, 0x0000_0000 without.
REQ-026 READ_LATENCY=2, port 1 reads addresses 0..7 on consecutive cycles -> dvalid1 high 8 consecutive cycles, data in order.
REQ-027 Issue port 0 read, assert rst_n=0 next cycle -> no dvalid0, outputs 0; memory written before reset still reads back unchanged.
REQ-028 Write with wmask0=0 to addr 0x40 read concurrently on port 1 -> memory unchanged, collision=0.

Source files
------------

// File: rtl/sram_1rw1r_param.sv
// Dual-port SRAM: port 0 read/write with per-lane write mask, port 1 read-only.
// Read data is presented READ_LATENCY (1 or 2) cycles after the sampling edge. Optional macro
// SRAM_BYPASS_EN forwards the merged write data to a port 1 read of the same address.
module sram_1rw1r_param #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned WMASK_WIDTH  = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              csb0,
  input  logic                              web0,
  input  logic [DATA_WIDTH/WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]             addr0,
  input  logic [DATA_WIDTH-1:0]             din0,
  output logic [DATA_WIDTH-1:0]             dout0,
  output logic                              dvalid0,
  input  logic                              csb1,
  input  logic [ADDR_WIDTH-1:0]             addr1,
  output logic [DATA_WIDTH-1:0]             dout1,
  output logic                              dvalid1,
  output logic                              collision
);

  localparam int unsigned NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;
  localparam int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_wmask
    $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  logic                  w_wr0;
  logic                  w_rd0;
  logic                  w_rd1;
  logic                  w_col;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rdata1;

  logic                  r_s1_v0;
  logic                  r_s1_v1;
  logic                  r_s1_col;
  logic [DATA_WIDTH-1:0] r_s1_d0;
  logic [DATA_WIDTH-1:0] r_s1_d1;

  assign w_wr0 = !csb0 && !web0;
  assign w_rd0 = !csb0 && web0;
  assign w_rd1 = !csb1;
  assign w_col = w_wr0 && w_rd1 && (wmask0 != '0) && (addr0 == addr1);

  // Word as it will look after this write; also the bypass value for a colliding read.
  always_comb begin
    w_merged = r_mem[addr0];
    for (int i = 0; i < int'(NUM_WMASKS); i++) begin
      if (wmask0[i]) begin
        w_merged[i*WMASK_WIDTH +: WMASK_WIDTH] = din0[i*WMASK_WIDTH +: WMASK_WIDTH];
      end
    end
  end

`ifdef SRAM_BYPASS_EN
  assign w_rdata1 = w_col ? w_merged : r_mem[addr1];
`else
  assign w_rdata1 = r_mem[addr1];
`endif

  always_ff @(posedge clk) begin
    if (rst_n && w_wr0) begin
      r_mem[addr0] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v0  <= 1'b0;
      r_s1_v1  <= 1'b0;
      r_s1_col <= 1'b0;
      r_s1_d0  <= '0;
      r_s1_d1  <= '0;
    end else begin
      r_s1_v0  <= w_rd0;
      r_s1_v1  <= w_rd1;
      r_s1_col <= w_col;
      if (w_rd0) r_s1_d0 <= r_mem[addr0];
      if (w_rd1) r_s1_d1 <= w_rdata1;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  r_s2_v0;
    logic                  r_s2_v1;
    logic                  r_s2_col;
    logic [DATA_WIDTH-1:0] r_s2_d0;
    logic [DATA_WIDTH-1:0] r_s2_d1;

    // Data registers load only on a valid stage-1 entry so outputs hold between reads.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_s2_v0  <= 1'b0;
        r_s2_v1  <= 1'b0;
        r_s2_col <= 1'b0;
        r_s2_d0  <= '0;
        r_s2_d1  <= '0;
      end else begin
        r_s2_v0  <= r_s1_v0;
        r_s2_v1  <= r_s1_v1;
        r_s2_col <= r_s1_col;
        if (r_s1_v0) r_s2_d0 <= r_s1_d0;
        if (r_s1_v1) r_s2_d1 <= r_s1_d1;
      end
    end

    assign dout0     = r_s2_d0;
    assign dvalid0   = r_s2_v0;
    assign dout1     = r_s2_d1;
    assign dvalid1   = r_s2_v1;
    assign collision = r_s2_col;
  end else begin : g_lat1
    assign dout0     = r_s1_d0;
    assign dvalid0   = r_s1_v0;
    assign dout1     = r_s1_d1;
    assign dvalid1   = r_s1_v1;
    assign collision = r_s1_col;
  end

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: READ_LATENCY 1 and 2 instances driven in lockstep, checked
// against an array-based memory model plus directed vector table and latency sequence.
module tb_sram_1rw1r_param;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int MW = 8;
  localparam int NM = DW / MW;
  localparam int HN = 8192;
`ifdef SRAM_BYPASS_EN
  localparam logic [31:0] COL_D = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] COL_D = 32'h0000_0000;
`endif

  logic          clk = 1'b0;
  logic          rst_n, csb0, web0, csb1;
  logic [NM-1:0] wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0_a, dout1_a, dout0_b, dout1_b;
  logic          dvalid0_a, dvalid1_a, col_a, dvalid0_b, dvalid1_b, col_b;

  always #5 clk = ~clk;

  sram_1rw1r_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .READ_LATENCY(1)
  ) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0_a), .dvalid0(dvalid0_a), .csb1(csb1), .addr1(addr1),
    .dout1(dout1_a), .dvalid1(dvalid1_a), .collision(col_a)
  );

  sram_1rw1r_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .READ_LATENCY(2)
  ) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0_b), .dvalid0(dvalid0_b), .csb1(csb1), .addr1(addr1),
    .dout1(dout1_b), .dvalid1(dvalid1_b), .collision(col_b)
  );

  // Reference model: memory array plus per-edge history of what each read returned.
  logic [DW-1:0] m_mem [2**AW];
  logic          h_rst [HN];
  logic          h_v0  [HN];
  logic          h_v1  [HN];
  logic          h_col [HN];
  logic [DW-1:0] h_d0  [HN];
  logic [DW-1:0] h_d1  [HN];
  logic          e_v0 [2];
  logic          e_v1 [2];
  logic          e_col[2];
  logic [DW-1:0] e_d0 [2];
  logic [DW-1:0] e_d1 [2];
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] md;
    h_rst[cyc] = !rst_n;
    h_v0[cyc]  = 1'b0;
    h_v1[cyc]  = 1'b0;
    h_col[cyc] = 1'b0;
    h_d0[cyc]  = '0;
    h_d1[cyc]  = '0;
    if (rst_n) begin
      md = m_mem[addr0];
      for (int l = 0; l < NM; l++) if (wmask0[l]) md[l*MW +: MW] = din0[l*MW +: MW];
      h_v0[cyc]  = !csb0 && web0;
      h_d0[cyc]  = m_mem[addr0];
      h_v1[cyc]  = !csb1;
      h_col[cyc] = !csb0 && !web0 && !csb1 && (wmask0 != '0) && (addr0 == addr1);
      h_d1[cyc]  = m_mem[addr1];
`ifdef SRAM_BYPASS_EN
      if (h_col[cyc]) h_d1[cyc] = md;
`endif
      if (!csb0 && !web0) m_mem[addr0] = md;
    end
    // Instance k returns at this edge what was issued k edges ago, unless reset intervened.
    for (int k = 0; k < 2; k++) begin
      int s;
      s = cyc - k;
      if (s >= 0 && !h_rst[cyc]) begin
        e_v0[k]  = h_v0[s];
        e_v1[k]  = h_v1[s];
        e_col[k] = h_col[s];
      end else begin
        e_v0[k]  = 1'b0;
        e_v1[k]  = 1'b0;
        e_col[k] = 1'b0;
      end
      if (h_rst[cyc]) begin
        e_d0[k] = '0;
        e_d1[k] = '0;
      end else begin
        if (e_v0[k]) e_d0[k] = h_d0[s];
        if (e_v1[k]) e_d1[k] = h_d1[s];
      end
    end
  endtask

  task automatic model_check();
    chk("l1_dvalid0", {31'b0, dvalid0_a}, {31'b0, e_v0[0]});
    chk("l1_dout0", dout0_a, e_d0[0]);
    chk("l1_dvalid1", {31'b0, dvalid1_a}, {31'b0, e_v1[0]});
    chk("l1_dout1", dout1_a, e_d1[0]);
    chk("l1_collision", {31'b0, col_a}, {31'b0, e_col[0]});
    chk("l2_dvalid0", {31'b0, dvalid0_b}, {31'b0, e_v0[1]});
    chk("l2_dout0", dout0_b, e_d0[1]);
    chk("l2_dvalid1", {31'b0, dvalid1_b}, {31'b0, e_v1[1]});
    chk("l2_dout1", dout1_b, e_d1[1]);
    chk("l2_collision", {31'b0, col_b}, {31'b0, e_col[1]});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    model_check();
  endtask

  task automatic idle();
    rst_n = 1'b1; csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; addr1 = '0;
  endtask

  typedef struct {
    logic        r, c0, w0;
    logic [3:0]  m;
    logic [7:0]  a0;
    logic [31:0] d;
    logic        c1;
    logic [7:0]  a1;
    logic        ev0;
    logic [31:0] ed0;
    logic        ev1;
    logic [31:0] ed1;
    logic        ec;
  } vec_t;

  vec_t tbl [19];

  initial begin
    // Directed rows; expected outputs are for the latency-1 instance right after the edge.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'hF, 8'h10, 32'hA5A5_A5A5, 1'b1, 8'h00,
                1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b1, 8'h00,
                1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'hF, 8'h20, 32'h1122_3344, 1'b1, 8'h00,
                1'b0, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'h5, 8'h20, 32'hFFFF_FFFF, 1'b1, 8'h00,
                1'b0, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h20,
                1'b0, 32'hA5A5_A5A5, 1'b1, 32'h11FF_33FF, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'hF, 8'h30, 32'h0, 1'b1, 8'h00,
                1'b0, 32'hA5A5_A5A5, 1'b0, 32'h11FF_33FF, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'hF, 8'h30, 32'hDEAD_BEEF, 1'b0, 8'h30,
                1'b0, 32'hA5A5_A5A5, 1'b1, COL_D, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h30,
                1'b0, 32'hA5A5_A5A5, 1'b1, 32'hDEAD_BEEF, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'hF, 8'h40, 32'h1234_5678, 1'b1, 8'h00,
                1'b0, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h40, 32'hFFFF_FFFF, 1'b0, 8'h40,
                1'b0, 32'hA5A5_A5A5, 1'b1, 32'h1234_5678, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 8'h40,
                1'b1, 32'hA5A5_A5A5, 1'b1, 32'h1234_5678, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 4'h0, 8'h20, 32'h0, 1'b0, 8'h20,
                1'b1, 32'h11FF_33FF, 1'b1, 32'h11FF_33FF, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00,
                1'b0, 32'h11FF_33FF, 1'b0, 32'h11FF_33FF, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 4'hF, 8'h50, 32'hFFFF_FFFF, 1'b0, 8'h50,
                1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 4'h0, 8'h50, 32'h0, 1'b1, 8'h00,
                1'b1, 32'hC0DE_0050, 1'b0, 32'h0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b1, 8'h00,
                1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00,
                1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00,
                1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b1, 8'h00,
                1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0};

    idle();
    rst_n = 1'b0;
    step();
    step();

    // Give every word a known value so any later read has a defined expectation.
    for (int a = 0; a < 2**AW; a++) begin
      idle();
      csb0 = 1'b0; web0 = 1'b0; wmask0 = '1; addr0 = AW'(a); din0 = 32'hC0DE_0000 | a;
      step();
    end

    for (int i = 0; i < 19; i++) begin
      rst_n = tbl[i].r; csb0 = tbl[i].c0; web0 = tbl[i].w0; wmask0 = tbl[i].m;
      addr0 = tbl[i].a0; din0 = tbl[i].d; csb1 = tbl[i].c1; addr1 = tbl[i].a1;
      step();
      chk($sformatf("vec%0d_dvalid0", i), {31'b0, dvalid0_a}, {31'b0, tbl[i].ev0});
      chk($sformatf("vec%0d_dout0", i), dout0_a, tbl[i].ed0);
      chk($sformatf("vec%0d_dvalid1", i), {31'b0, dvalid1_a}, {31'b0, tbl[i].ev1});
      chk($sformatf("vec%0d_dout1", i), dout1_a, tbl[i].ed1);
      chk($sformatf("vec%0d_collision", i), {31'b0, col_a}, {31'b0, tbl[i].ec});
    end

    // Latency-2 streaming: addresses 0..7 back to back give 8 consecutive valid words.
    idle();
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i < 8) begin
        csb1 = 1'b0; addr1 = AW'(i);
      end
      step();
      if (i >= 1 && i <= 8) begin
        chk($sformatf("stream%0d_dvalid1", i), {31'b0, dvalid1_b}, 32'd1);
        chk($sformatf("stream%0d_dout1", i), dout1_b, 32'hC0DE_0000 + 32'(i - 1));
      end else begin
        chk($sformatf("stream%0d_dvalid1", i), {31'b0, dvalid1_b}, 32'd0);
      end
    end

    // Random traffic on a narrow address window so collisions are frequent.
    for (int n = 0; n < 1500; n++) begin
      rst_n  = ($urandom_range(0, 49) != 0);
      csb0   = ($urandom_range(0, 3) == 0);
      web0   = $urandom_range(0, 1) != 0;
      wmask0 = NM'($urandom);
      addr0  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      din0   = $urandom;
      csb1   = ($urandom_range(0, 3) == 0);
      addr1  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      step();
    end

    idle();
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
